arm_seq_ctrl: RTL and testbench
===============================

Name: arm_seq_ctrl

Overview:
- Multi-cycle sequencer for the non-pipelined Harvard core.
- Owns the PC and instruction register (IR).
- Drives the one-hot state bus consumed by arm_alu and the register file: bit0 FETCH, bit1 EXEC1, bit2 EXEC2.
- Resolves branches and halt, stalls LDR's second execute cycle on a data-memory ready handshake, and counts retired instructions.

Parameters:
- PC_W, 16: PC and instruction-address width.
- RESET_PC, 0: PC value loaded on reset.
- START_HALTED, 0: 1 = leave reset in HALT and wait for go; 0 = leave reset in FETCH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_data  in  16  instruction memory read data for address i_addr; combinational read, valid in the same cycle.
- rd_data  in  16  register-file Rd read value, used by BZ.
- d_ready  in  1  data memory has completed the LDR access; sampled only in EXEC2.
- go  in  1  leave HALT; ignored in all other states.
- step_en  in  1  single-step: enter HALT after every retired instruction.
- i_addr  out  PC_W  instruction fetch address; equals pc.
- inst  out  16  IR contents, broadcast to the ALU and register file.
- state  out  3  one-hot {EXEC2, EXEC1, FETCH}; 3'b000 = HALT.
- halted  out  1  high while in HALT.
- instret  out  16  count of retired instructions.

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-EXEC2):
  - pc=RESET_PC, ir=0, instret=0.
  - state=3'b001, or 3'b000 if START_HALTED=1.
  - halted follows state.
- Decode classes (from ir):
  - ARM: ir[15]=1.
  - LDR: ir[15:12]=4'b1110.
  - B: ir[15:13]=3'b000.
  - MOVX: ir[15:13]=3'b001; sequential, no sequencer action.
  - BZ: ir[15:13]=3'b010.
  - HLT: ir[15:13]=3'b011.
- FETCH (001):
  - ir <= i_data.
  - Next state EXEC1.
  - pc unchanged.
- EXEC1 (010):
  - LDR: next EXEC2; pc and instret unchanged.
  - Otherwise the instruction retires this edge: instret += 1 (16-bit wrap, FFFF -> 0000).
  - Next pc on retire:
    - B: pc + sext(ir[11:0]) to PC_W.
    - BZ: pc + sext(ir[7:0]) if rd_data==16'h0000, else pc+1.
    - HLT: pc+1.
    - All others: pc+1.
    - All pc arithmetic is modulo 2^PC_W.
  - Next state on retire: HALT if HLT or step_en=1, else FETCH.
- EXEC2 (100):
  - d_ready=0: hold state, pc, ir, instret. No cycle limit.
  - d_ready=1: retire; pc+1, instret += 1. Next state HALT if step_en=1, else FETCH.
- HALT (000):
  - pc, ir and instret hold.
  - go=1: next FETCH. go=0: stay.
  - go asserted in any other state has no effect and is not remembered.
- Branch offsets:
  - Relative to the address of the branch itself.
  - B with offset 0 is a legal self-loop.
  - Wrap below 0 or above 2^PC_W-1 is silent.
- Cycle cost:
  - Non-LDR instruction: 2 cycles.
  - LDR: 3 cycles plus one cycle per d_ready=0 cycle in EXEC2.
- Outputs: all registered except i_addr (= pc) and halted (= state==000); no combinational path from any input to any output.
- step_en is sampled only on the retire edge.

Test Plan:
1. Reset, RESET_PC=0, START_HALTED=0; imem[0..2] = three ARM ops, imem[3] = HLT.
   -> state sequence 001,010 repeated 4 times, then 000.
   -> halted=1, pc=4, instret=4 after 8 cycles.
2. imem[5] = LDR; d_ready held 0 for 3 cycles, then 1.
   -> state 001,010,100,100,100,100,001.
   -> pc 5 -> 6 only on the d_ready edge; instret +1 once.
3. B at pc=0x0010, ir[11:0]=12'hFFC -> next fetch address 0x000C.
   BZ at 0x0020, ir[7:0]=8'h08:
   -> rd_data=0: pc=0x0028.
   -> rd_data=0x0001: pc=0x0021.
4. step_en=1, go pulsed one cycle while in HALT:
   -> exactly one instruction executes (2 cycles), returns to 000, instret +1.
   -> go pulsed during EXEC1 is ignored.
5. rst asserted in EXEC2 with d_ready=0:
   -> next cycle state=001, pc=RESET_PC, ir=0, instret=0.
   -> START_HALTED=1 variant: state=000 until go.
6. instret preloaded to 0xFFFF by running 65535 ARM ops (or forced), one more retire -> instret=0x0000.
   B at pc=0xFFFF with offset +2 -> pc=0x0001.

Source files
------------

// File: rtl/arm_seq_ctrl.sv
// arm_seq_ctrl: multi-cycle fetch/execute sequencer owning PC, IR and retired-instruction count
module arm_seq_ctrl #(
    parameter int PC_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter bit START_HALTED = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     i_data,
    input  logic [15:0]     rd_data,
    input  logic            d_ready,
    input  logic            go,
    input  logic            step_en,
    output logic [PC_W-1:0] i_addr,
    output logic [15:0]     inst,
    output logic [2:0]      state,
    output logic            halted,
    output logic [15:0]     instret
);
    typedef enum logic [2:0] {HALT = 3'b000, FETCH = 3'b001, EXEC1 = 3'b010, EXEC2 = 3'b100} st_t;
    st_t st;
    logic [PC_W-1:0] pc, pc_inc, pc_ret;
    logic is_ldr, is_b, is_bz, is_hlt;
    assign is_ldr = inst[15:12] == 4'b1110;
    assign is_b   = inst[15:13] == 3'b000;
    assign is_bz  = inst[15:13] == 3'b010;
    assign is_hlt = inst[15:13] == 3'b011;
    assign pc_inc = pc + PC_W'(1);
    assign pc_ret = is_b ? pc + PC_W'($signed(inst[11:0])) :
                    (is_bz && rd_data == 16'h0000) ? pc + PC_W'($signed(inst[7:0])) : pc_inc;
    assign i_addr = pc;
    assign state  = st;
    assign halted = st == HALT;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            inst    <= '0;
            instret <= '0;
            st      <= START_HALTED ? HALT : FETCH;
        end else begin
            case (st)
                HALT: if (go) st <= FETCH;
                FETCH: begin
                    inst <= i_data;
                    st   <= EXEC1;
                end
                EXEC1: if (is_ldr) st <= EXEC2;
                else begin
                    pc      <= pc_ret;
                    instret <= instret + 16'd1;
                    st      <= (is_hlt || step_en) ? HALT : FETCH;
                end
                EXEC2: if (d_ready) begin
                    pc      <= pc_inc;
                    instret <= instret + 16'd1;
                    st      <= step_en ? HALT : FETCH;
                end
                default: st <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_arm_seq_ctrl.sv
// tb_arm_seq_ctrl: directed bench with an instruction-level reference model checked every cycle
module tb_arm_seq_ctrl;
    logic clk = 1'b0, rst, go, go2, step_en, d_ready, preload, chk_en;
    logic [15:0] rd_data, i_data, i_addr, inst, instret;
    logic [15:0] i_addr2, inst2, instret2;
    logic [2:0] state, state2;
    logic halted, halted2;
    logic [15:0] imem [0:65535];
    logic [15:0] m_pc, m_ir, m_cnt;
    int m_ph;
    int n_cmp = 0, n_bad = 0;
    logic [15:0] fa[$], ic[$];
    logic [2:0]  e1 [9] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd0};
    logic [2:0]  e2 [7] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1};
    logic [15:0] e3 [7] = '{16'h0007, 16'h0010, 16'h000C, 16'h0020, 16'h0028, 16'h0020, 16'h0021};
    logic [15:0] e6a [6] = '{16'h0023, 16'h0000, 16'hFFFF, 16'h0001, 16'h0002, 16'h0003};
    logic [15:0] e6b [6] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

    always #5 clk = ~clk;
    assign i_data = imem[i_addr];

    arm_seq_ctrl dut (.clk(clk), .rst(rst), .i_data(i_data), .rd_data(rd_data), .d_ready(d_ready),
        .go(go), .step_en(step_en), .i_addr(i_addr), .inst(inst), .state(state), .halted(halted),
        .instret(instret));

    arm_seq_ctrl #(.START_HALTED(1'b1)) dut2 (.clk(clk), .rst(rst), .i_data(16'h0000),
        .rd_data(16'h0000), .d_ready(1'b0), .go(go2), .step_en(1'b0), .i_addr(i_addr2),
        .inst(inst2), .state(state2), .halted(halted2), .instret(instret2));

    // phase: 0 halted, 1 fetch, 2 first execute, 3 waiting on data memory
    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 16'h0000; m_ir <= 16'h0000; m_cnt <= 16'h0000; m_ph <= 1;
        end else if (preload) begin
            m_cnt <= 16'hFFFF;
        end else if (m_ph == 0) begin
            if (go) m_ph <= 1;
        end else if (m_ph == 1) begin
            m_ir <= imem[m_pc]; m_ph <= 2;
        end else if (m_ph == 2 && m_ir[15:12] == 4'hE) begin
            m_ph <= 3;
        end else if (m_ph == 2 || d_ready) begin
            if (m_ph == 2 && m_ir[15:13] == 3'b000)
                m_pc <= m_pc + {{4{m_ir[11]}}, m_ir[11:0]};
            else if (m_ph == 2 && m_ir[15:13] == 3'b010 && rd_data == 16'h0000)
                m_pc <= m_pc + {{8{m_ir[7]}}, m_ir[7:0]};
            else
                m_pc <= m_pc + 16'd1;
            m_cnt <= m_cnt + 16'd1;
            m_ph <= (step_en || (m_ph == 2 && m_ir[15:13] == 3'b011)) ? 0 : 1;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("m_state", 32'(state), m_ph == 1 ? 32'd1 : m_ph == 2 ? 32'd2 : m_ph == 3 ? 32'd4 : 32'd0);
        chk("m_pc", 32'(i_addr), 32'(m_pc));
        chk("m_inst", 32'(inst), 32'(m_ir));
        chk("m_instret", 32'(instret), 32'(m_cnt));
        chk("m_halted", 32'(halted), 32'(m_ph == 0));
    end

    task automatic wait_halt(int n);
        for (int k = 0; k < n && !halted; k++) @(negedge clk);
        chk("halt_timeout", 32'(halted), 32'd1);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 65536; a++) imem[a] = 16'h8000;
        imem[0] = 16'h8000; imem[1] = 16'h8001; imem[2] = 16'h8002; imem[3] = 16'h6000;
        imem[4] = 16'h8000; imem[5] = 16'hE000; imem[6] = 16'h6000; imem[7] = 16'h0009;
        imem[16'h10] = 16'h0FFC; imem[16'h0C] = 16'h0014; imem[16'h20] = 16'h4008;
        imem[16'h28] = 16'h0FF8; imem[16'h21] = 16'h6000; imem[16'h22] = 16'h8000;
        imem[16'h23] = 16'h0FDD;
        rst = 1'b1; go = 1'b0; go2 = 1'b0; step_en = 1'b0; d_ready = 1'b0;
        rd_data = 16'h0000; preload = 1'b0; chk_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; chk_en = 1'b1;
        chk("rst_pc", 32'(i_addr), 32'h0);
        chk("rst_instret", 32'(instret), 32'h0);
        chk("rst_dut2_state", 32'(state2), 32'h0);
        // three ARM ops then HLT
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_state%0d", i), 32'(state), 32'(e1[i]));
            @(negedge clk);
        end
        chk("t1_pc", 32'(i_addr), 32'h4);
        chk("t1_instret", 32'(instret), 32'h4);
        chk("t1_halted", 32'(halted), 32'h1);
        chk("t1_dut2_halted", 32'(halted2), 32'h1);
        // LDR with three wait cycles
        pulse_go();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            d_ready = (i == 5);
            chk($sformatf("t2_state%0d", i), 32'(state), 32'(e2[i]));
            chk($sformatf("t2_pc%0d", i), 32'(i_addr), i == 6 ? 32'h6 : 32'h5);
            chk($sformatf("t2_instret%0d", i), 32'(instret), i == 6 ? 32'h6 : 32'h5);
            @(negedge clk);
        end
        d_ready = 1'b0;
        wait_halt(20);
        chk("t2_end_pc", 32'(i_addr), 32'h7);
        chk("t2_end_instret", 32'(instret), 32'h7);
        // branch chain: B forward, B back, BZ taken, BZ not taken
        pulse_go();
        for (int k = 0; k < 60 && !halted; k++) begin
            if (state == 3'b001) begin
                fa.push_back(i_addr);
                if (i_addr == 16'h0028) rd_data = 16'h0001;
            end
            @(negedge clk);
        end
        chk("t3_halted", 32'(halted), 32'h1);
        chk("t3_nfetch", 32'(fa.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t3_fetch%0d", i), i < fa.size() ? 32'(fa[i]) : 32'hDEAD, 32'(e3[i]));
        chk("t3_pc", 32'(i_addr), 32'h22);
        chk("t3_instret", 32'(instret), 32'd14);
        rd_data = 16'h0000;
        // single step, go during EXEC1 ignored
        step_en = 1'b1;
        pulse_go();
        chk("t4_fetch", 32'(state), 32'h1);
        @(negedge clk);
        chk("t4_exec1", 32'(state), 32'h2);
        pulse_go();
        chk("t4_back_halt", 32'(state), 32'h0);
        repeat (3) @(negedge clk);
        chk("t4_still_halt", 32'(state), 32'h0);
        chk("t4_instret", 32'(instret), 32'd15);
        chk("t4_pc", 32'(i_addr), 32'h23);
        step_en = 1'b0;
        // instret wrap and PC wrap through 0xFFFF
        chk_en = 1'b0;
        imem[0] = 16'h0FFF; imem[16'hFFFF] = 16'h0002;
        force dut.instret = 16'hFFFF;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        release dut.instret;
        chk_en = 1'b1;
        chk("t6_preload", 32'(instret), 32'hFFFF);
        fa.delete();
        pulse_go();
        for (int k = 0; k < 40 && !halted; k++) begin
            if (state == 3'b001) begin
                fa.push_back(i_addr);
                ic.push_back(instret);
            end
            @(negedge clk);
        end
        chk("t6_halted", 32'(halted), 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t6_fetch%0d", i), i < fa.size() ? 32'(fa[i]) : 32'hDEAD, 32'(e6a[i]));
            chk($sformatf("t6_instret%0d", i), i < ic.size() ? 32'(ic[i]) : 32'hDEAD, 32'(e6b[i]));
        end
        chk("t6_pc", 32'(i_addr), 32'h4);
        chk("t6_instret", 32'(instret), 32'h5);
        // reset while stalled in EXEC2
        pulse_go();
        for (int k = 0; k < 20 && state != 3'b100; k++) @(negedge clk);
        chk("t5_reach_exec2", 32'(state), 32'h4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_state", 32'(state), 32'h1);
        chk("t5_pc", 32'(i_addr), 32'h0);
        chk("t5_inst", 32'(inst), 32'h0);
        chk("t5_instret", 32'(instret), 32'h0);
        chk("t5_dut2_state", 32'(state2), 32'h0);
        repeat (3) @(negedge clk);
        chk("t5_dut2_wait", 32'(halted2), 32'h1);
        go2 = 1'b1;
        @(negedge clk);
        go2 = 1'b0;
        chk("t5_dut2_go", 32'(state2), 32'h1);
        wait_halt(40);
        chk("t5_end_pc", 32'(i_addr), 32'h4);
        chk("t5_end_instret", 32'(instret), 32'h5);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
